// File: rtl/graphite_pkg.sv
// Shared types for the graphite command path.
// Command words are 32-bit, assembled big-endian from UART bytes.
package graphite_pkg;

    localparam int CMD_WIDTH = 32;
    localparam int CMD_BYTES = 4;

    typedef logic [CMD_WIDTH-1:0] cmd_word_t;
    typedef logic [7:0] rx_byte_t;
    typedef logic [CMD_WIDTH-9:0] cmd_head_t;
    typedef logic [$clog2(CMD_BYTES)-1:0] byte_idx_t;

    localparam byte_idx_t FIRST_IDX = '0;
    localparam byte_idx_t LAST_IDX = byte_idx_t'(CMD_BYTES - 1);
    localparam byte_idx_t IDX_STEP = byte_idx_t'(1);

    function automatic cmd_word_t pack_word(
        input cmd_head_t head,
        input rx_byte_t  tail
    );
        return {head, tail};
    endfunction

    function automatic cmd_head_t shift_head(
        input cmd_head_t head,
        input rx_byte_t  data
    );
        return {head[CMD_WIDTH-17:0], data};
    endfunction

endpackage

// File: rtl/uart_cmd_assembler_fifo.sv
// Generic synchronous show-ahead FIFO with registered full/empty flags.
// Only pointers and flags are reset; storage contents are don't-care.
module cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
    localparam logic [AW:0] LVL_STEP = (AW + 1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      level_nxt;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + LVL_STEP;
        end else if (!do_push && do_pop) begin
            level_nxt = level - LVL_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_STEP;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_STEP;
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_FULL);
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs UART rx bytes into big-endian command words and queues them
// for graphite on an AXI-stream port; stalled partial words time out.
module uart_cmd_assembler
    import graphite_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    input  logic                        byte_valid_i,
    input  logic [7:0]                  byte_data_i,
    output logic                        byte_ready_o,
    output logic                        cmd_axis_tvalid_o,
    input  logic                        cmd_axis_tready_i,
    output logic [CMD_WIDTH-1:0]        cmd_axis_tdata_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        frame_error_o,
    input  logic                        clear_error_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_STEP = TW'(1);

    byte_idx_t     idx;
    cmd_head_t     head;
    logic [TW-1:0] tcnt;

    logic          accept;
    logic          last_byte;
    logic          push;
    logic          pop;
    logic          expire;
    cmd_word_t     push_word;
    cmd_word_t     head_word;
    logic          fifo_full;
    logic          fifo_empty;

    assign last_byte    = (idx == LAST_IDX);
    assign byte_ready_o = !(last_byte && fifo_full);
    assign accept       = byte_valid_i && byte_ready_o;
    assign push         = accept && last_byte;
    assign push_word    = pack_word(head, byte_data_i);

    // An accepted byte on the expiry cycle keeps the partial word alive.
    assign expire = (idx != FIRST_IDX) && !accept && (tcnt == T_LAST);

    assign cmd_axis_tvalid_o = !fifo_empty;
    assign cmd_axis_tdata_o  = fifo_empty ? '0 : head_word;
    assign pop               = cmd_axis_tvalid_o && cmd_axis_tready_i;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            idx  <= FIRST_IDX;
            head <= '0;
            tcnt <= '0;
        end else if (accept) begin
            tcnt <= '0;
            if (last_byte) begin
                idx  <= FIRST_IDX;
                head <= '0;
            end else begin
                idx  <= idx + IDX_STEP;
                head <= shift_head(head, byte_data_i);
            end
        end else if (expire) begin
            idx  <= FIRST_IDX;
            head <= '0;
            tcnt <= '0;
        end else if (idx != FIRST_IDX) begin
            tcnt <= tcnt + T_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            frame_error_o <= 1'b0;
        end else if (expire) begin
            frame_error_o <= 1'b1;
        end else if (clear_error_i) begin
            frame_error_o <= 1'b0;
        end
    end

    cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n_i),
        .push  (push),
        .wdata (push_word),
        .pop   (pop),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level_o)
    );

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for uart_cmd_assembler with a short timeout.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_uart_cmd_assembler;

    localparam int DEPTH = 8;
    localparam int TO    = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        cmd_tvalid;
    logic        cmd_tready = 1'b0;
    logic [31:0] cmd_tdata;
    logic [3:0]  level;
    logic        frame_error;
    logic        clear_error = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    int          got5;
    int          cyc5;
    logic        stalled5;
    logic [31:0] held5;
    int          stale;

    always #5 clk = ~clk;

    uart_cmd_assembler #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset_n_i         (reset_n),
        .byte_valid_i      (byte_valid),
        .byte_data_i       (byte_data),
        .byte_ready_o      (byte_ready),
        .cmd_axis_tvalid_o (cmd_tvalid),
        .cmd_axis_tready_i (cmd_tready),
        .cmd_axis_tdata_o  (cmd_tdata),
        .fifo_level_o      (level),
        .frame_error_o     (frame_error),
        .clear_error_i     (clear_error)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && w < 50) begin
            tick(1);
            w++;
        end
        checks++;
        assert (byte_ready === 1'b1) else begin
            failures++;
            $error("FAIL send_byte_wait observed=stalled expected=ready");
        end
        tick(1);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[i*8 +: 8]);
        end
    endtask

    task automatic drain(input int nexp, input string tag);
        int  got;
        int  cyc;
        logic pend;
        got = 0;
        cyc = 0;
        cmd_tready = 1'b1;
        while (got < nexp && cyc < 200) begin
            if (cmd_tvalid) begin
                check(tag, cmd_tdata, exp_q.pop_front());
                got++;
            end
            pend = byte_valid && byte_ready;
            tick(1);
            cyc++;
            if (pend) byte_valid = 1'b0;
        end
        check({tag, "_count"}, got, nexp);
    endtask

    initial begin
        tick(2);
        check("rst_tvalid", cmd_tvalid, 0);
        check("rst_tdata", cmd_tdata, 0);
        check("rst_level", level, 0);
        check("rst_err", frame_error, 0);
        check("rst_ready", byte_ready, 1);
        reset_n = 1'b1;
        tick(1);

        // 1: single word with tready high
        cmd_tready = 1'b1;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        check("t1_no_early_valid", cmd_tvalid, 0);
        send_byte(8'h78);
        check("t1_tvalid", cmd_tvalid, 1);
        check("t1_tdata", cmd_tdata, 32'h12345678);
        check("t1_level1", level, 1);
        tick(1);
        check("t1_popped", cmd_tvalid, 0);
        check("t1_level0", level, 0);

        // 2: fill to full, backpressure only on byte 3 of the 9th word
        cmd_tready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back({8'hA0 + 8'(k), 8'h10 + 8'(k),
                             8'h20 + 8'(k), 8'h30 + 8'(k)});
        end
        for (int k = 0; k < 8; k++) begin
            send_word(exp_q[k]);
        end
        check("t2_level_full", level, 8);
        check("t2_ready_idx0", byte_ready, 1);
        send_byte(8'hA8);
        check("t2_ready_idx1", byte_ready, 1);
        send_byte(8'h18);
        send_byte(8'h28);
        check("t2_ready_idx3", byte_ready, 0);
        byte_valid = 1'b1;
        byte_data  = 8'h38;
        tick(3);
        check("t2_ready_held", byte_ready, 0);
        check("t2_level_held", level, 8);
        check("t2_head_stable", cmd_tdata, 32'hA0102030);
        drain(9, "t2_word");
        check("t2_level_end", level, 0);
        check("t2_valid_end", cmd_tvalid, 0);

        // 3: timeout drops a partial word
        exp_q.delete();
        send_byte(8'hAA);
        send_byte(8'hBB);
        tick(TO - 1);
        check("t3_err_before", frame_error, 0);
        tick(1);
        check("t3_err_set", frame_error, 1);
        check("t3_nothing_out", cmd_tvalid, 0);
        send_word(32'h01020304);
        check("t3_tvalid", cmd_tvalid, 1);
        check("t3_tdata", cmd_tdata, 32'h01020304);
        check("t3_err_sticky", frame_error, 1);
        tick(1);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        check("t3_err_cleared", frame_error, 0);
        send_byte(8'h55);
        tick(TO - 1);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        check("t3_drop_beats_clear", frame_error, 1);
        clear_error = 1'b1;
        tick(1);
        clear_error = 1'b0;
        check("t3_err_cleared2", frame_error, 0);
        check("t3_level", level, 0);

        // 4: byte lands exactly on the expiry cycle
        send_byte(8'hC1);
        send_byte(8'hC2);
        tick(TO - 1);
        send_byte(8'hC3);
        check("t4_no_drop_err", frame_error, 0);
        send_byte(8'hC4);
        check("t4_tvalid", cmd_tvalid, 1);
        check("t4_tdata", cmd_tdata, 32'hC1C2C3C4);
        check("t4_err", frame_error, 0);
        tick(1);
        check("t4_level", level, 0);

        // 5: toggling tready against a continuous byte stream
        exp_q.delete();
        for (int w = 0; w < 6; w++) begin
            exp_q.push_back({8'h50 + 8'(w), 8'h60 + 8'(w),
                             8'h70 + 8'(w), 8'h80 + 8'(w)});
        end
        cmd_tready = 1'b0;
        got5 = 0;
        cyc5 = 0;
        stalled5 = 1'b0;
        held5 = '0;
        fork
            begin
                for (int w = 0; w < 6; w++) begin
                    send_word({8'h50 + 8'(w), 8'h60 + 8'(w),
                               8'h70 + 8'(w), 8'h80 + 8'(w)});
                end
            end
            begin
                while (got5 < 6 && cyc5 < 400) begin
                    if (stalled5) begin
                        check("t5_hold_valid", cmd_tvalid, 1);
                        check("t5_hold_data", cmd_tdata, held5);
                    end
                    if (cmd_tvalid && cmd_tready) begin
                        check("t5_word", cmd_tdata, exp_q.pop_front());
                        got5++;
                    end
                    stalled5 = cmd_tvalid && !cmd_tready;
                    held5 = cmd_tdata;
                    tick(1);
                    cyc5++;
                    cmd_tready = !cmd_tready;
                end
            end
        join
        check("t5_count", got5, 6);
        tick(1);
        check("t5_level", level, 0);

        // 6: async reset mid-word with words queued
        cmd_tready = 1'b0;
        send_byte(8'h99);
        tick(TO);
        check("t6_err_pre", frame_error, 1);
        send_word(32'hE0E1E2E3);
        send_word(32'hE4E5E6E7);
        send_word(32'hE8E9EAEB);
        send_byte(8'hEC);
        send_byte(8'hED);
        check("t6_level_pre", level, 3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_tvalid", cmd_tvalid, 0);
        check("t6_rst_tdata", cmd_tdata, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_err", frame_error, 0);
        check("t6_rst_ready", byte_ready, 1);
        tick(2);
        reset_n = 1'b1;
        cmd_tready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_tvalid) stale++;
            tick(1);
        end
        check("t6_no_stale", stale, 0);
        send_word(32'h0D0E0F10);
        check("t6_tvalid", cmd_tvalid, 1);
        check("t6_tdata", cmd_tdata, 32'h0D0E0F10);
        tick(1);
        check("t6_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
